debug_unit_ctrl: RTL and testbench
==================================

DEBUG_UNIT_CTRL -- requirements
Module: debug_unit_ctrl

Interface
REQ-001 SHALL have parameter N_WORDS, default 64, total words dumped (32 registers followed by 32 data-memory words).
REQ-002 SHALL have i_clock  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have i_reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have i_rx_data  in  8  command byte from the UART receiver.
REQ-005 SHALL have i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
REQ-006 SHALL have i_halt  in  1  HALT instruction has reached the WB stage.
REQ-007 SHALL have i_dump_data  in  32  combinational read data for o_dump_sel/o_dump_addr.
REQ-008 SHALL have i_tx_done  in  1  one-cycle strobe: UART transmitter finished the current byte.
REQ-009 SHALL have o_pipe_enable  out  1  global pipeline enable (PC, all stage registers, register-file write).
REQ-010 SHALL have o_dump_sel  out  1  0 = register file, 1 = data memory.
REQ-011 SHALL have o_dump_addr  out  5  word index into the selected storage.
REQ-012 SHALL have o_tx_data  out  8  byte to transmit.
REQ-013 SHALL have o_tx_start  out  1  one-cycle strobe launching transmission of o_tx_data.
REQ-014 SHALL have o_halted  out  1  the program has finished; high from dump completion until reset.

Function
REQ-015 SHALL implement states IDLE, RUN, STEP, LOAD, SEND, WAIT and HALTED.
REQ-016 IDLE: i_rx_valid with 0x43 ('C') -> RUN; with 0x53 ('S') -> STEP; any other byte is ignored and the state stays IDLE.
REQ-017 i_rx_valid SHALL be ignored in every state other than IDLE.
REQ-018 RUN: o_pipe_enable = !i_halt (combinational); i_halt high -> LOAD next cycle, halt flag set.
REQ-019 STEP: o_pipe_enable high for exactly this one cycle; -> LOAD next cycle; halt flag set if i_halt is high in this cycle.
REQ-020 o_pipe_enable SHALL be 0 in every state other than RUN and STEP.
REQ-021 A 6-bit word counter SHALL drive o_dump_sel = cnt[5] and o_dump_addr = cnt[4:0]; it is cleared on every entry to LOAD from RUN or STEP.
REQ-022 LOAD: capture i_dump_data into a 32-bit shift register, clear the 2-bit byte counter, -> SEND.
REQ-023 SEND: o_tx_start = 1 for this single cycle, o_tx_data = shift register [31:24] (MSB first), -> WAIT.
REQ-024 WAIT: on i_tx_done, shift the register left by 8 bits; if byte counter < 3, increment it and -> SEND; else continue per REQ-025.
REQ-025 After byte 3: if word counter < N_WORDS-1, increment it and -> LOAD; else -> HALTED if the halt flag is set, otherwise -> IDLE.
REQ-026 i_tx_done outside WAIT SHALL be ignored.
REQ-027 One dump SHALL therefore emit exactly 4*N_WORDS = 256 bytes: registers 0..31, then memory words 0..31.
REQ-028 HALTED: o_halted = 1, o_pipe_enable = 0, all commands ignored; only reset leaves this state.
REQ-029 o_tx_data SHALL hold its value from SEND until the next SEND.

Reset
REQ-030 i_reset high at a clock edge SHALL force IDLE, clear the halt flag, word counter, byte counter and shift register; this takes priority over all other inputs.
REQ-031 Outputs while in reset and immediately after reset: o_pipe_enable = 0, o_tx_start = 0, o_tx_data = 0x00, o_dump_sel = 0, o_dump_addr = 0, o_halted = 0.
REQ-032 A reset during RUN, STEP or a dump SHALL abort the operation with no further o_tx_start pulses.

Verification
REQ-033 Step with no HALT: send 'S' -> o_pipe_enable high for exactly 1 cycle, then 256 o_tx_start pulses; reg 1 = 0x12345678 is sent as bytes 4..7 = 0x12, 0x34, 0x56, 0x78; controller returns to IDLE with o_halted = 0.
REQ-034 Continuous run: send 'C', assert i_halt after 10 cycles -> o_pipe_enable = 0 in the same cycle; 256-byte dump follows; then o_halted = 1, and 'S' or 'C' produce no response.
REQ-035 Command filtering: send 0x41, and send 'S' during a dump -> no state change and no extra pipeline cycle; the byte count stays exactly 256.
REQ-036 Transmitter backpressure: delay i_tx_done by 0..20 random cycles, inject spurious i_tx_done in LOAD/SEND -> exactly one o_tx_start per byte; o_tx_data is stable until the next SEND.
REQ-037 Reset mid-dump: assert i_reset after byte 100 -> next cycle IDLE with all outputs at reset values; a following 'S' produces a full, fresh 256-byte dump starting at register 0.
REQ-038 i_halt during a step: 'S' with i_halt high in the STEP cycle -> full dump, then HALTED with o_halted = 1.

Source files
------------

// File: rtl/debug_unit_ctrl_if.sv
// -----------------------------------------------------------------------------
// debug_unit_ctrl_if
//   Signals between the debug unit controller and its surroundings (UART
//   receiver/transmitter, pipeline and dump read mux). The clock and reset
//   stay plain ports on the controller.
//
//   i_rx_data   [7:0]  command byte from the UART receiver
//   i_rx_valid         one-cycle strobe qualifying i_rx_data
//   i_halt             HALT instruction has reached the WB stage
//   i_dump_data [31:0] combinational read data for o_dump_sel/o_dump_addr
//   i_tx_done          one-cycle strobe: transmitter finished current byte
//   o_pipe_enable      global pipeline enable
//   o_dump_sel         0 = register file, 1 = data memory
//   o_dump_addr [4:0]  word index into the selected storage
//   o_tx_data   [7:0]  byte to transmit
//   o_tx_start         one-cycle strobe launching transmission of o_tx_data
//   o_halted           program finished; high from dump completion until reset
//
//   modport slave  : the controller
//   modport master : the environment driving the controller
// -----------------------------------------------------------------------------
interface debug_unit_ctrl_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_halt;
  logic [31:0] i_dump_data;
  logic        i_tx_done;
  logic        o_pipe_enable;
  logic        o_dump_sel;
  logic [4:0]  o_dump_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_halted;

  modport slave (
    input  i_rx_data, i_rx_valid, i_halt, i_dump_data, i_tx_done,
    output o_pipe_enable, o_dump_sel, o_dump_addr, o_tx_data, o_tx_start,
           o_halted
  );

  modport master (
    output i_rx_data, i_rx_valid, i_halt, i_dump_data, i_tx_done,
    input  o_pipe_enable, o_dump_sel, o_dump_addr, o_tx_data, o_tx_start,
           o_halted
  );
endinterface

// File: rtl/debug_unit_ctrl.sv
// -----------------------------------------------------------------------------
// debug_unit_ctrl
//   Debug controller for a pipelined CPU. Accepts 'C' (continuous run) and
//   'S' (single step) commands over UART. When a run reaches HALT, or after a
//   single step, it dumps N_WORDS 32-bit words (32 registers then 32 data
//   memory words) MSB first, one byte per transmitter handshake. After a dump
//   that followed a HALT the controller parks in HALTED until reset.
//
//   Parameters
//     N_WORDS   total words dumped (default 64)
//   Ports
//     i_clock   single clock, rising edge
//     i_reset   synchronous active-high reset
//     bus       debug_unit_ctrl_if.slave (UART, pipeline and dump signals)
// -----------------------------------------------------------------------------
module debug_unit_ctrl #(
  parameter int N_WORDS = 64
) (
  input  logic               i_clock,
  input  logic               i_reset,
  debug_unit_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_HALTED
  } state_t;

  localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [5:0] LAST_WORD = 6'(N_WORDS - 1);

  state_t      state;
  logic        halt_flag;   // dump was triggered by HALT -> park in HALTED
  logic [5:0]  word_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] shift_reg;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        halted;

  always_ff @(posedge i_clock) begin
    // NOTE: state registers use non-blocking assignments so every branch
    // below reads the pre-edge values, whatever the statement order.
    if (i_reset) begin
      state     <= S_IDLE;
      halt_flag <= 1'b0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      // tx_start is a single-cycle pulse; only the branches entering SEND
      // raise it.
      tx_start <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (bus.i_rx_valid) begin
            if (bus.i_rx_data == CMD_CONT) begin
              state <= S_RUN;
            end else if (bus.i_rx_data == CMD_STEP) begin
              state <= S_STEP;
            end
          end
        end

        S_RUN: begin
          if (bus.i_halt) begin
            halt_flag <= 1'b1;
            word_cnt  <= '0;
            state     <= S_LOAD;
          end
        end

        S_STEP: begin
          if (bus.i_halt) begin
            halt_flag <= 1'b1;
          end
          word_cnt <= '0;
          state    <= S_LOAD;
        end

        // tx_data is registered so it is valid in the SEND cycle; the first
        // byte comes straight from the read data being captured here.
        S_LOAD: begin
          shift_reg <= bus.i_dump_data;
          byte_cnt  <= '0;
          tx_data   <= bus.i_dump_data[31:24];
          tx_start  <= 1'b1;
          state     <= S_SEND;
        end

        S_SEND: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.i_tx_done) begin
            shift_reg <= shift_reg << 8;
            if (byte_cnt != 2'd3) begin
              byte_cnt <= byte_cnt + 2'd1;
              // Next byte is what will sit at [31:24] after this shift.
              tx_data  <= shift_reg[23:16];
              tx_start <= 1'b1;
              state    <= S_SEND;
            end else if (word_cnt < LAST_WORD) begin
              word_cnt <= word_cnt + 6'd1;
              state    <= S_LOAD;
            end else if (halt_flag) begin
              halted <= 1'b1;
              state  <= S_HALTED;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_HALTED: begin
          state <= S_HALTED;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The pipeline must freeze in the very cycle HALT reaches WB, so RUN
  // gates the enable combinationally with i_halt.
  assign bus.o_pipe_enable = ((state == S_RUN) && !bus.i_halt) || (state == S_STEP);
  assign bus.o_dump_sel    = word_cnt[5];
  assign bus.o_dump_addr   = word_cnt[4:0];
  assign bus.o_tx_data     = tx_data;
  assign bus.o_tx_start    = tx_start;
  assign bus.o_halted      = halted;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_debug_unit_ctrl
//   Directed bench for debug_unit_ctrl. A memory model supplies dump data from
//   the DUT's address, a transmitter model answers each o_tx_start with
//   i_tx_done after a configurable delay, and a monitor records sent bytes,
//   pipeline-enable cycles and o_tx_data stability.
// -----------------------------------------------------------------------------
module tb_debug_unit_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_unit_ctrl_if bus();

  debug_unit_ctrl #(.N_WORDS(64)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] tx_q[$];
  int         pe_count     = 0;
  int         stab_err     = 0;
  logic [7:0] last_tx      = 8'h00;
  int         tx_delay_max = 0;
  bit         inject       = 1'b0;
  bit         pending      = 1'b0;
  int         countdown    = 0;

  // Word k of the dump: k = {sel, addr}. Register 1 holds 0x12345678.
  function automatic logic [31:0] word_of(int k);
    logic [7:0] a;
    a = 8'(k);
    if (k == 1) return 32'h1234_5678;
    return {a, ~a, 8'(k * 3 + 1), a ^ 8'hA5};
  endfunction

  assign bus.i_dump_data = word_of(int'({bus.o_dump_sel, bus.o_dump_addr}));

  // Number of bytes in tx_q that differ from a complete 256-byte dump.
  function automatic int dump_mismatches();
    int         e;
    logic [31:0] w;
    logic [7:0]  exp_b;
    e = 0;
    for (int i = 0; i < 256; i++) begin
      w     = word_of(i / 4);
      exp_b = w[31 - 8 * (i % 4) -: 8];
      if (i >= tx_q.size() || tx_q[i] !== exp_b) e++;
    end
    if (tx_q.size() > 256) e += tx_q.size() - 256;
    return e;
  endfunction

  // Monitor and transmitter model, both sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.o_pipe_enable === 1'b1) pe_count++;
    if (rst) begin
      last_tx = 8'h00;
    end else if (bus.o_tx_start === 1'b1) begin
      tx_q.push_back(bus.o_tx_data);
      last_tx = bus.o_tx_data;
    end else if (bus.o_tx_data !== last_tx) begin
      stab_err++;
    end

    bus.i_tx_done = 1'b0;
    if (rst) begin
      pending = 1'b0;
    end else if (bus.o_tx_start === 1'b1) begin
      pending   = 1'b1;
      countdown = (tx_delay_max == 0) ? 0 : int'($urandom_range(tx_delay_max, 0));
      if (inject && $urandom_range(1, 0) == 1) bus.i_tx_done = 1'b1;  // lands in SEND
    end else if (pending) begin
      if (countdown == 0) begin
        bus.i_tx_done = 1'b1;
        pending       = 1'b0;
      end else begin
        countdown--;
      end
    end else if (inject && $urandom_range(2, 0) == 0) begin
      bus.i_tx_done = 1'b1;  // lands in LOAD or outside a dump
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(logic [7:0] b);
    @(posedge clk);
    #1;
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
  endtask

  task automatic clear_stats();
    tx_q.delete();
    pe_count = 0;
    stab_err = 0;
  endtask

  task automatic wait_bytes(int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Wait for a full dump, then let the controller settle so any stray
  // extra byte would also be recorded.
  task automatic wait_dump(output bit ok);
    wait_bytes(256, ok);
    tick(60);
  endtask

  task automatic test_reset();
    tick(2);
    tests_run++; if (bus.o_pipe_enable !== 1'b0) begin tests_failed++; $display("FAIL rst_pipe_enable: got %b expected 0", bus.o_pipe_enable); end
    tests_run++; if (bus.o_tx_start !== 1'b0) begin tests_failed++; $display("FAIL rst_tx_start: got %b expected 0", bus.o_tx_start); end
    tests_run++; if (bus.o_tx_data !== 8'h00) begin tests_failed++; $display("FAIL rst_tx_data: got %h expected 00", bus.o_tx_data); end
    tests_run++; if (bus.o_dump_sel !== 1'b0) begin tests_failed++; $display("FAIL rst_dump_sel: got %b expected 0", bus.o_dump_sel); end
    tests_run++; if (bus.o_dump_addr !== 5'd0) begin tests_failed++; $display("FAIL rst_dump_addr: got %0d expected 0", bus.o_dump_addr); end
    tests_run++; if (bus.o_halted !== 1'b0) begin tests_failed++; $display("FAIL rst_halted: got %b expected 0", bus.o_halted); end
    rst = 1'b0;
    tick(3);
    tests_run++; if (bus.o_pipe_enable !== 1'b0) begin tests_failed++; $display("FAIL idle_pipe_enable: got %b expected 0", bus.o_pipe_enable); end
    tests_run++; if (tx_q.size() != 0) begin tests_failed++; $display("FAIL idle_no_tx: got %0d bytes expected 0", tx_q.size()); end
  endtask

  task automatic test_step_no_halt();
    bit ok;
    clear_stats();
    bus.i_halt = 1'b0;
    send_cmd(8'h53);
    wait_dump(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL step_timeout: got %0d bytes expected 256", tx_q.size()); end
    tests_run++; if (pe_count != 1) begin tests_failed++; $display("FAIL step_pe_cycles: got %0d expected 1", pe_count); end
    tests_run++; if (tx_q.size() != 256) begin tests_failed++; $display("FAIL step_byte_count: got %0d expected 256", tx_q.size()); end
    tests_run++; if (dump_mismatches() != 0) begin tests_failed++; $display("FAIL step_dump_data: got %0d bad bytes expected 0", dump_mismatches()); end
    tests_run++; if (tx_q[4] !== 8'h12) begin tests_failed++; $display("FAIL step_byte4: got %h expected 12", tx_q[4]); end
    tests_run++; if (tx_q[5] !== 8'h34) begin tests_failed++; $display("FAIL step_byte5: got %h expected 34", tx_q[5]); end
    tests_run++; if (tx_q[6] !== 8'h56) begin tests_failed++; $display("FAIL step_byte6: got %h expected 56", tx_q[6]); end
    tests_run++; if (tx_q[7] !== 8'h78) begin tests_failed++; $display("FAIL step_byte7: got %h expected 78", tx_q[7]); end
    tests_run++; if (bus.o_halted !== 1'b0) begin tests_failed++; $display("FAIL step_halted: got %b expected 0", bus.o_halted); end
  endtask

  task automatic test_filter();
    bit ok;
    clear_stats();
    send_cmd(8'h41);
    tick(20);
    tests_run++; if (pe_count != 0) begin tests_failed++; $display("FAIL filter_41_pe: got %0d expected 0", pe_count); end
    tests_run++; if (tx_q.size() != 0) begin tests_failed++; $display("FAIL filter_41_tx: got %0d expected 0", tx_q.size()); end
    send_cmd(8'h53);
    wait_bytes(20, ok);
    send_cmd(8'h53);
    send_cmd(8'h43);
    wait_dump(ok);
    tests_run++; if (pe_count != 1) begin tests_failed++; $display("FAIL filter_pe_cycles: got %0d expected 1", pe_count); end
    tests_run++; if (tx_q.size() != 256) begin tests_failed++; $display("FAIL filter_byte_count: got %0d expected 256", tx_q.size()); end
    tests_run++; if (dump_mismatches() != 0) begin tests_failed++; $display("FAIL filter_dump_data: got %0d bad bytes expected 0", dump_mismatches()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_stats();
    tx_delay_max = 20;
    inject       = 1'b1;
    send_cmd(8'h53);
    wait_dump(ok);
    inject       = 1'b0;
    tx_delay_max = 0;
    tests_run++; if (tx_q.size() != 256) begin tests_failed++; $display("FAIL bp_byte_count: got %0d expected 256", tx_q.size()); end
    tests_run++; if (dump_mismatches() != 0) begin tests_failed++; $display("FAIL bp_dump_data: got %0d bad bytes expected 0", dump_mismatches()); end
    tests_run++; if (stab_err != 0) begin tests_failed++; $display("FAIL bp_tx_data_stable: got %0d changes expected 0", stab_err); end
    tests_run++; if (pe_count != 1) begin tests_failed++; $display("FAIL bp_pe_cycles: got %0d expected 1", pe_count); end
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    clear_stats();
    send_cmd(8'h53);
    wait_bytes(101, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rmd_reach_100: got %0d bytes expected 101", tx_q.size()); end
    rst = 1'b1;
    tick();
    tests_run++; if (bus.o_tx_start !== 1'b0) begin tests_failed++; $display("FAIL rmd_tx_start: got %b expected 0", bus.o_tx_start); end
    tests_run++; if (bus.o_tx_data !== 8'h00) begin tests_failed++; $display("FAIL rmd_tx_data: got %h expected 00", bus.o_tx_data); end
    tests_run++; if ({bus.o_dump_sel, bus.o_dump_addr} !== 6'd0) begin tests_failed++; $display("FAIL rmd_dump_addr: got %0d expected 0", {bus.o_dump_sel, bus.o_dump_addr}); end
    tests_run++; if (bus.o_pipe_enable !== 1'b0) begin tests_failed++; $display("FAIL rmd_pipe_enable: got %b expected 0", bus.o_pipe_enable); end
    tests_run++; if (bus.o_halted !== 1'b0) begin tests_failed++; $display("FAIL rmd_halted: got %b expected 0", bus.o_halted); end
    rst = 1'b0;
    clear_stats();
    tick(40);
    tests_run++; if (tx_q.size() != 0) begin tests_failed++; $display("FAIL rmd_aborted: got %0d bytes expected 0", tx_q.size()); end
    send_cmd(8'h53);
    wait_dump(ok);
    tests_run++; if (tx_q.size() != 256) begin tests_failed++; $display("FAIL rmd_fresh_count: got %0d expected 256", tx_q.size()); end
    tests_run++; if (dump_mismatches() != 0) begin tests_failed++; $display("FAIL rmd_fresh_data: got %0d bad bytes expected 0", dump_mismatches()); end
  endtask

  task automatic test_run_halt();
    bit ok;
    clear_stats();
    bus.i_halt = 1'b0;
    send_cmd(8'h43);
    repeat (10) @(posedge clk);
    #1;
    bus.i_halt = 1'b1;
    #1;
    tests_run++; if (bus.o_pipe_enable !== 1'b0) begin tests_failed++; $display("FAIL run_pe_same_cycle: got %b expected 0", bus.o_pipe_enable); end
    wait_dump(ok);
    tests_run++; if (pe_count != 10) begin tests_failed++; $display("FAIL run_pe_cycles: got %0d expected 10", pe_count); end
    tests_run++; if (tx_q.size() != 256) begin tests_failed++; $display("FAIL run_byte_count: got %0d expected 256", tx_q.size()); end
    tests_run++; if (dump_mismatches() != 0) begin tests_failed++; $display("FAIL run_dump_data: got %0d bad bytes expected 0", dump_mismatches()); end
    tests_run++; if (bus.o_halted !== 1'b1) begin tests_failed++; $display("FAIL run_halted: got %b expected 1", bus.o_halted); end
    clear_stats();
    send_cmd(8'h53);
    send_cmd(8'h43);
    tick(30);
    tests_run++; if (tx_q.size() != 0 || pe_count != 0) begin tests_failed++; $display("FAIL halted_ignores_cmds: got %0d bytes %0d pe expected 0 0", tx_q.size(), pe_count); end
    tests_run++; if (bus.o_halted !== 1'b1) begin tests_failed++; $display("FAIL halted_sticky: got %b expected 1", bus.o_halted); end
    bus.i_halt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tests_run++; if (bus.o_halted !== 1'b0) begin tests_failed++; $display("FAIL halted_reset: got %b expected 0", bus.o_halted); end
  endtask

  task automatic test_halt_in_step();
    bit ok;
    clear_stats();
    bus.i_halt = 1'b1;
    send_cmd(8'h53);
    wait_dump(ok);
    tests_run++; if (pe_count != 1) begin tests_failed++; $display("FAIL hstep_pe_cycles: got %0d expected 1", pe_count); end
    tests_run++; if (tx_q.size() != 256) begin tests_failed++; $display("FAIL hstep_byte_count: got %0d expected 256", tx_q.size()); end
    tests_run++; if (dump_mismatches() != 0) begin tests_failed++; $display("FAIL hstep_dump_data: got %0d bad bytes expected 0", dump_mismatches()); end
    tests_run++; if (bus.o_halted !== 1'b1) begin tests_failed++; $display("FAIL hstep_halted: got %b expected 1", bus.o_halted); end
    bus.i_halt = 1'b0;
  endtask

  initial begin
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_halt     = 1'b0;
    test_reset();
    test_step_no_halt();
    test_filter();
    test_backpressure();
    test_reset_mid_dump();
    test_run_halt();
    test_halt_in_step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
